// File: rtl/writeback_arbiter.sv
// writeback_arbiter: four-source round-robin arbiter funnelling writeback requests into a single
// register-file write port, with per-source holding slots, supersede and overflow detection.
module writeback_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [3:0]                req_enable,
   input  logic [4*ADDR_WIDTH-1:0]   req_addr,
   input  logic [4*DATA_WIDTH-1:0]   req_data,
   input  logic [3:0]                req_float,
   output logic                      rf_write_enable,
   output logic [ADDR_WIDTH-1:0]     rf_write_addr,
   output logic [DATA_WIDTH-1:0]     rf_write_data,
   output logic                      rf_write_float,
   output logic [3:0]                pending,
   output logic                      stall,
   output logic                      overflow
);
   logic [3:0]            valid_q, valid_d;
   logic [ADDR_WIDTH-1:0] addr_q [4];
   logic [DATA_WIDTH-1:0] data_q [4];
   logic [3:0]            float_q;
   logic [1:0]            last_q, last_d;
   logic                  ovf_q, ovf_d;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] waddr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  wfloat_q;
   logic                  any_gnt;
   logic [1:0]            gnt_idx;
   logic [3:0]            gnt, elig, keep, cap, kill;
   logic                  ovf_set;

   always_comb begin
      any_gnt = 1'b0;
      gnt_idx = last_q;
      for (int k = 1; k <= 4; k++)
         if (!any_gnt && valid_q[last_q + 2'(k)]) begin
            any_gnt = 1'b1;
            gnt_idx = last_q + 2'(k);
         end
      gnt = any_gnt ? 4'b1 << gnt_idx : 4'b0;
   end

   // x0 integer writes are discarded; among same-edge duplicates only the highest source survives
   always_comb begin
      elig    = '0;
      keep    = '0;
      cap     = '0;
      kill    = '0;
      ovf_set = 1'b0;
      for (int i = 0; i < 4; i++)
         elig[i] = req_enable[i] && (req_float[i] || req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] != '0);
      keep = elig;
      for (int i = 0; i < 4; i++)
         for (int j = i + 1; j < 4; j++)
            if (elig[j] && req_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]
                && req_float[j] == req_float[i])
               keep[i] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cap[i]  = keep[i] && (!valid_q[i] || gnt[i]);
         ovf_set = ovf_set | (keep[i] && valid_q[i] && !gnt[i]);
      end
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            if (cap[i] && i != j && valid_q[j] && !gnt[j]
                && addr_q[j] == req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] && float_q[j] == req_float[i])
               kill[j] = 1'b1;
      valid_d = cap | (valid_q & ~gnt & ~kill);
      ovf_d   = ovf_q | ovf_set;
      last_d  = any_gnt ? gnt_idx : last_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q  <= '0;
         float_q  <= '0;
         last_q   <= 2'd3;
         ovf_q    <= 1'b0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         wfloat_q <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         last_q  <= last_d;
         ovf_q   <= ovf_d;
         we_q    <= any_gnt;
         if (any_gnt) begin
            waddr_q  <= addr_q[gnt_idx];
            wdata_q  <= data_q[gnt_idx];
            wfloat_q <= float_q[gnt_idx];
         end
         for (int i = 0; i < 4; i++)
            if (cap[i]) begin
               addr_q[i]  <= req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
               data_q[i]  <= req_data[i*DATA_WIDTH +: DATA_WIDTH];
               float_q[i] <= req_float[i];
            end
      end
   end

   assign rf_write_enable = we_q;
   assign rf_write_addr   = waddr_q;
   assign rf_write_data   = wdata_q;
   assign rf_write_float  = wfloat_q;
   assign pending         = valid_q;
   assign stall           = (valid_q & (valid_q - 4'd1)) != 4'd0;
   assign overflow        = ovf_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed vectors with hand-computed expectations for writeback_arbiter.
module tb_writeback_arbiter;
   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [3:0]    req_enable = '0;
   logic [4*AW-1:0] req_addr = '0;
   logic [4*DW-1:0] req_data = '0;
   logic [3:0]    req_float = '0;
   logic          rf_write_enable;
   logic [AW-1:0] rf_write_addr;
   logic [DW-1:0] rf_write_data;
   logic          rf_write_float;
   logic [3:0]    pending;
   logic          stall;
   logic          overflow;
   int            n_tests = 0;
   int            n_fail = 0;

   writeback_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset), .req_enable(req_enable), .req_addr(req_addr),
      .req_data(req_data), .req_float(req_float), .rf_write_enable(rf_write_enable),
      .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
      .rf_write_float(rf_write_float), .pending(pending), .stall(stall), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input int src, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic f);
      req_enable[src]           = 1'b1;
      req_addr[src*AW +: AW]    = a;
      req_data[src*DW +: DW]    = d;
      req_float[src]            = f;
   endtask

   task automatic do_reset();
      req_enable = '0;
      reset = 1'b0;
      #3;
      reset = 1'b1;
   endtask

   task automatic wr(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic f);
      chk({tag, "_we"}, rf_write_enable, 1'b1);
      chk({tag, "_addr"}, rf_write_addr, a);
      chk({tag, "_data"}, rf_write_data, d);
      chk({tag, "_float"}, rf_write_float, f);
   endtask

   initial begin
      #2;
      chk("rst_we", rf_write_enable, 1'b0);
      chk("rst_addr", rf_write_addr, 0);
      chk("rst_data", rf_write_data, 0);
      chk("rst_float", rf_write_float, 1'b0);
      chk("rst_pend", pending, 4'b0000);
      chk("rst_stall", stall, 1'b0);
      chk("rst_ovf", overflow, 1'b0);
      tick();
      reset = 1'b1;

      // single alu request: visible two edges later for exactly one cycle
      req(1, 5'd7, 32'h12345678, 1'b0);
      tick(); req_enable = '0;
      chk("alu_pend", pending, 4'b0010);
      chk("alu_we0", rf_write_enable, 1'b0);
      tick();
      wr("alu", 5'd7, 32'h12345678, 1'b0);
      chk("alu_pend2", pending, 4'b0000);
      tick();
      chk("alu_we_off", rf_write_enable, 1'b0);
      chk("alu_hold", rf_write_addr, 5'd7);

      // all four on the same edge: order misc, alu, mem, fpu
      do_reset();
      for (int i = 0; i < 4; i++) req(i, AW'(i + 1), DW'(32'h100 + i), 1'b0);
      tick(); req_enable = '0;
      chk("all_pend", pending, 4'b1111);
      chk("all_stall0", stall, 1'b1);
      tick(); wr("all_misc", 5'd1, 32'h100, 1'b0); chk("all_stall1", stall, 1'b1);
      tick(); wr("all_alu", 5'd2, 32'h101, 1'b0); chk("all_stall2", stall, 1'b1);
      tick(); wr("all_mem", 5'd3, 32'h102, 1'b0); chk("all_stall3", stall, 1'b0);
      tick(); wr("all_fpu", 5'd4, 32'h103, 1'b0); chk("all_stall4", stall, 1'b0);
      tick(); chk("all_done", rf_write_enable, 1'b0);

      // integer x0 discarded, float f0 written
      do_reset();
      req(0, 5'd0, 32'hDEAD, 1'b0);
      tick(); req_enable = '0;
      chk("x0_pend", pending, 4'b0000);
      tick();
      chk("x0_we", rf_write_enable, 1'b0);
      chk("x0_ovf", overflow, 1'b0);
      req(3, 5'd0, 32'hF0, 1'b1);
      tick(); req_enable = '0;
      chk("f0_pend", pending, 4'b1000);
      tick(); wr("f0", 5'd0, 32'hF0, 1'b1);

      // supersede: mem's newer addr 5 kills the waiting alu addr 5
      do_reset();
      req(0, 5'd10, 32'h10, 1'b0);
      req(1, 5'd5, 32'h55, 1'b0);
      tick(); req_enable = '0;
      chk("sup_pend0", pending, 4'b0011);
      req(2, 5'd5, 32'hAA, 1'b0);
      tick(); req_enable = '0;
      wr("sup_misc", 5'd10, 32'h10, 1'b0);
      chk("sup_pend1", pending, 4'b0100);
      tick(); wr("sup_mem", 5'd5, 32'hAA, 1'b0);
      chk("sup_pend2", pending, 4'b0000);
      tick(); chk("sup_done", rf_write_enable, 1'b0);
      chk("sup_ovf", overflow, 1'b0);

      // same-edge duplicate: highest source kept, no overflow
      do_reset();
      req(0, 5'd20, 32'h1, 1'b0);
      req(2, 5'd20, 32'h3, 1'b0);
      tick(); req_enable = '0;
      chk("dup_pend", pending, 4'b0100);
      tick(); wr("dup", 5'd20, 32'h3, 1'b0);
      chk("dup_ovf", overflow, 1'b0);
      tick(); chk("dup_done", rf_write_enable, 1'b0);

      // reload while granted: no overflow, new contents follow
      do_reset();
      req(0, 5'd12, 32'hC1, 1'b0);
      tick();
      req(0, 5'd13, 32'hC2, 1'b0);
      tick(); req_enable = '0;
      wr("rl_first", 5'd12, 32'hC1, 1'b0);
      chk("rl_pend", pending, 4'b0001);
      chk("rl_ovf", overflow, 1'b0);
      tick(); wr("rl_second", 5'd13, 32'hC2, 1'b0);

      // mem requests twice while alu is pending: second dropped, overflow sticky
      do_reset();
      req(1, 5'd3, 32'h33, 1'b0);
      req(2, 5'd9, 32'h91, 1'b0);
      tick(); req_enable = '0;
      req(2, 5'd9, 32'h92, 1'b0);
      tick(); req_enable = '0;
      wr("ov_alu", 5'd3, 32'h33, 1'b0);
      chk("ov_pend", pending, 4'b0100);
      chk("ov_set", overflow, 1'b1);
      tick(); wr("ov_mem", 5'd9, 32'h91, 1'b0);
      tick();
      chk("ov_done", rf_write_enable, 1'b0);
      chk("ov_sticky", overflow, 1'b1);

      // reset mid-operation with three slots pending
      do_reset();
      chk("ov_cleared", overflow, 1'b0);
      req(0, 5'd1, 32'hA1, 1'b0);
      req(1, 5'd2, 32'hA2, 1'b0);
      req(2, 5'd3, 32'hA3, 1'b0);
      tick(); req_enable = '0;
      chk("mr_pend0", pending, 4'b0111);
      tick();
      wr("mr_misc", 5'd1, 32'hA1, 1'b0);
      reset = 1'b0;
      #1;
      chk("mr_pend", pending, 4'b0000);
      chk("mr_we", rf_write_enable, 1'b0);
      chk("mr_addr", rf_write_addr, 0);
      #2;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("mr_idle%0d", i), rf_write_enable, 1'b0);
      end
      chk("mr_pend_end", pending, 4'b0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
